scan_select_sequencer: RTL and testbench

//  Upstream driver for the 3-to-8 enable decoder. Steps a 3-bit channel index through the

---
 rtl/scan_seq_pkg.sv | 24 ++
 rtl/scan_next_ch.sv | 56 +++++
 rtl/scan_select_sequencer.sv | 170 +++++++++++++++++
 tb/tb_scan_select_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_seq_pkg
//  Description : Shared constants and FSM state encoding for the scan select
//                sequencer. The BLANK state exists only when the
//                SCAN_BLANK_EN macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package scan_seq_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1
`ifdef SCAN_BLANK_EN
        ,
        BLANK = 2'd2
`endif
    } state_t;

endpackage
`default_nettype wire

// File: rtl/scan_next_ch.sv
`default_nettype none
// ============================================================================
//  Module      : scan_next_ch
//  Description : Combinational channel search over an 8-bit enable mask.
//                nxt     - next set bit strictly above cur, modulo 8
//                          (cur itself when it is the only set bit)
//                first   - lowest set bit
//                last    - highest set bit
//                wrapped - nxt <= cur
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_next_ch
    import scan_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  nxt,
    output logic [SEL_W-1:0]  first,
    output logic [SEL_W-1:0]  last,
    output logic              wrapped
);

    logic [SEL_W-1:0] w_idx;
    logic             w_found;

    // Rotate upward from cur+1; the 3-bit sum wraps modulo 8 on its own,
    // and k=NUM_CH lands back on cur for the single-channel case.
    always_comb begin
        nxt     = cur;
        w_idx   = cur;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = cur + SEL_W'(k);
            if (!w_found && mask[w_idx]) begin
                nxt     = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // Lowest and highest enabled channel indices.
    always_comb begin
        first = '0;
        last  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) first = SEL_W'(i);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask[i]) last = SEL_W'(i);
        end
    end

    assign wrapped = (nxt <= cur);

endmodule
`default_nettype wire

// File: rtl/scan_select_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : scan_select_sequencer
//  Description : Steps a 3-bit channel index through the enabled channels of
//                an 8-bit mask, holding each for a programmable dwell time.
//                Drives the in/e pins of a 3-to-8 enable decoder.
//                Optional macro SCAN_BLANK_EN inserts a 1-cycle en=0 BLANK
//                state on every channel advance.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_select_sequencer
    import scan_seq_pkg::*;
#(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               oneshot,
    input  logic [NUM_CH-1:0]  ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               en,
    output logic               busy,
    output logic               wrap,
    output logic               done
);

    state_t              r_state,     n_state;
    logic [SEL_W-1:0]    r_sel,       n_sel;
    logic                r_en,        n_en;
    logic                r_busy,      n_busy;
    logic                r_wrap,      n_wrap;
    logic                r_done,      n_done;
    logic [DWELL_W-1:0]  r_dwell_cnt, n_dwell_cnt;
    logic [NUM_CH-1:0]   r_mask,      n_mask;
    logic [DWELL_W-1:0]  r_dwell_eff, n_dwell_eff;
    logic                r_oneshot,   n_oneshot;

    logic [NUM_CH-1:0]   w_mask_in;
    logic [SEL_W-1:0]    w_nxt;
    logic [SEL_W-1:0]    w_first;
    logic [SEL_W-1:0]    w_last;
    logic                w_wrapped;
    logic [DWELL_W-1:0]  w_dwell_in;

    // In IDLE the search runs on the incoming mask so 'first' gives the
    // start channel; otherwise it runs on the latched mask from r_sel.
    assign w_mask_in  = (r_state == IDLE) ? ch_mask : r_mask;
    assign w_dwell_in = (dwell == '0) ? DWELL_W'(1) : dwell;

    scan_next_ch u_next_ch (
        .mask    (w_mask_in),
        .cur     (r_sel),
        .nxt     (w_nxt),
        .first   (w_first),
        .last    (w_last),
        .wrapped (w_wrapped)
    );

    // State and output registers; every output is driven from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_wrap      <= 1'b0;
            r_done      <= 1'b0;
            r_dwell_cnt <= '0;
            r_mask      <= '0;
            r_dwell_eff <= '0;
            r_oneshot   <= 1'b0;
        end else begin
            r_state     <= n_state;
            r_sel       <= n_sel;
            r_en        <= n_en;
            r_busy      <= n_busy;
            r_wrap      <= n_wrap;
            r_done      <= n_done;
            r_dwell_cnt <= n_dwell_cnt;
            r_mask      <= n_mask;
            r_dwell_eff <= n_dwell_eff;
            r_oneshot   <= n_oneshot;
        end
    end

    // Next-state, dwell counter and next output values.
    always_comb begin
        n_state     = r_state;
        n_sel       = r_sel;
        n_en        = r_en;
        n_busy      = r_busy;
        n_wrap      = 1'b0;
        n_done      = 1'b0;
        n_dwell_cnt = r_dwell_cnt;
        n_mask      = r_mask;
        n_dwell_eff = r_dwell_eff;
        n_oneshot   = r_oneshot;

        case (r_state)
            IDLE: begin
                if (start && (ch_mask != '0)) begin
                    n_mask      = ch_mask;
                    n_dwell_eff = w_dwell_in;
                    n_oneshot   = oneshot;
                    n_sel       = w_first;
                    n_en        = 1'b1;
                    n_busy      = 1'b1;
                    n_dwell_cnt = w_dwell_in - DWELL_W'(1);
                    n_state     = SCAN;
                end
            end

            SCAN: begin
                if (stop) begin
                    n_state = IDLE;
                    n_en    = 1'b0;
                    n_busy  = 1'b0;
                end else if (r_dwell_cnt == '0) begin
                    if (r_oneshot && (r_sel == w_last)) begin
                        n_state = IDLE;
                        n_en    = 1'b0;
                        n_busy  = 1'b0;
                        n_done  = 1'b1;
                    end else begin
                        n_sel       = w_nxt;
                        n_wrap      = w_wrapped;
                        n_dwell_cnt = r_dwell_eff - DWELL_W'(1);
`ifdef SCAN_BLANK_EN
                        n_state     = BLANK;
                        n_en        = 1'b0;
`endif
                    end
                end else begin
                    n_dwell_cnt = r_dwell_cnt - DWELL_W'(1);
                end
            end

`ifdef SCAN_BLANK_EN
            // Counter was already reloaded on entry; just re-enable.
            BLANK: begin
                if (stop) begin
                    n_state = IDLE;
                    n_en    = 1'b0;
                    n_busy  = 1'b0;
                end else begin
                    n_state = SCAN;
                    n_en    = 1'b1;
                end
            end
`endif

            default: begin
                n_state = IDLE;
                n_en    = 1'b0;
                n_busy  = 1'b0;
            end
        endcase
    end

    assign sel  = r_sel;
    assign en   = r_en;
    assign busy = r_busy;
    assign wrap = r_wrap;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_scan_select_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_select_sequencer
//  Description : Directed self-checking bench for scan_select_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_select_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        oneshot;
    logic [7:0]  ch_mask;
    logic [15:0] dwell;
    logic [2:0]  sel;
    logic        en;
    logic        busy;
    logic        wrap;
    logic        done;

    int checks;
    int failures;

    scan_select_sequencer #(.DWELL_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .oneshot (oneshot),
        .ch_mask (ch_mask),
        .dwell   (dwell),
        .sel     (sel),
        .en      (en),
        .busy    (busy),
        .wrap    (wrap),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] m, input logic [15:0] d, input logic os);
        ch_mask = m;
        dwell   = d;
        oneshot = os;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        oneshot  = 1'b0;
        ch_mask  = 8'h00;
        dwell    = 16'd0;

        // ---------------- reset state
        step();
        step();
        chk("rst_sel",  32'(sel),  32'd0);
        chk("rst_en",   32'(en),   32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();

`ifndef SCAN_BLANK_EN
        // ---------------- 1: all channels, dwell 3, continuous
        do_start(8'hFF, 16'd3, 1'b0);
        for (int p = 0; p < 2; p++) begin
            for (int ch = 0; ch < 8; ch++) begin
                for (int k = 0; k < 3; k++) begin
                    chk("t1_sel",  32'(sel),  32'(ch));
                    chk("t1_en",   32'(en),   32'd1);
                    chk("t1_wrap", 32'(wrap), (p == 1 && ch == 0 && k == 0) ? 32'd1 : 32'd0);
                    step();
                end
            end
        end
        chk("t1_sel_pass3", 32'(sel),  32'd0);
        chk("t1_wrap_pass3", 32'(wrap), 32'd1);
        chk("t1_busy",      32'(busy), 32'd1);
        do_stop();
        chk("t1_stop_en",   32'(en),   32'd0);
        chk("t1_stop_busy", 32'(busy), 32'd0);
        chk("t1_stop_done", 32'(done), 32'd0);
        chk("t1_stop_sel",  32'(sel),  32'd0);
        step();

        // ---------------- 2: mask A4, dwell 2, oneshot
        do_start(8'hA4, 16'd2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            chk("t2_sel",  32'(sel),  (i < 2) ? 32'd2 : (i < 4) ? 32'd5 : 32'd7);
            chk("t2_en",   32'(en),   32'd1);
            chk("t2_done", 32'(done), 32'd0);
            chk("t2_wrap", 32'(wrap), 32'd0);
            step();
        end
        chk("t2_end_en",   32'(en),   32'd0);
        chk("t2_end_busy", 32'(busy), 32'd0);
        chk("t2_end_done", 32'(done), 32'd1);
        chk("t2_end_sel",  32'(sel),  32'd7);
        chk("t2_end_wrap", 32'(wrap), 32'd0);
        step();
        chk("t2_done_clr", 32'(done), 32'd0);
        chk("t2_sel_hold", 32'(sel),  32'd7);

        // ---------------- 3: dwell 0 treated as 1, mask 81
        do_start(8'h81, 16'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("t3_sel",  32'(sel),  (i % 2 == 0) ? 32'd0 : 32'd7);
            chk("t3_en",   32'(en),   32'd1);
            chk("t3_wrap", 32'(wrap), (i > 0 && i % 2 == 0) ? 32'd1 : 32'd0);
            step();
        end
        do_stop();
        chk("t3_stop_busy", 32'(busy), 32'd0);
        step();
`endif

        // ---------------- 4: empty mask start; start while busy; start+stop
        do_start(8'h00, 16'd4, 1'b1);
        chk("t4_empty_busy", 32'(busy), 32'd0);
        chk("t4_empty_en",   32'(en),   32'd0);
        chk("t4_empty_done", 32'(done), 32'd0);
        step();
        chk("t4_empty_busy2", 32'(busy), 32'd0);
        chk("t4_empty_done2", 32'(done), 32'd0);

        do_start(8'hFF, 16'd5, 1'b0);
        chk("t4_run_busy", 32'(busy), 32'd1);
        chk("t4_run_sel",  32'(sel),  32'd0);
        do_start(8'h80, 16'd1, 1'b1);
        chk("t4_ign_sel1", 32'(sel), 32'd0);
        step();
        chk("t4_ign_sel2", 32'(sel), 32'd0);
        chk("t4_ign_busy", 32'(busy), 32'd1);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("t4_ss_busy", 32'(busy), 32'd0);
        chk("t4_ss_en",   32'(en),   32'd0);
        chk("t4_ss_done", 32'(done), 32'd0);
        step();
        chk("t4_ss_busy2", 32'(busy), 32'd0);
        chk("t4_ss_done2", 32'(done), 32'd0);

        // ---------------- 5: asynchronous reset mid-scan
        do_start(8'hFF, 16'd3, 1'b0);
        step();
        step();
        step();
        chk("t5_pre_sel", 32'(sel), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_sel",  32'(sel),  32'd0);
        chk("t5_async_en",   32'(en),   32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_idle_busy", 32'(busy), 32'd0);
            chk("t5_idle_en",   32'(en),   32'd0);
        end

`ifdef SCAN_BLANK_EN
        // ---------------- 6: blank cycle between channels
        do_start(8'h03, 16'd2, 1'b0);
        for (int i = 0; i < 9; i++) begin
            chk("t6_en",   32'(en),   (i % 3 == 2) ? 32'd0 : 32'd1);
            chk("t6_sel",  32'(sel),  ((i + 1) / 3 % 2 == 0) ? 32'd0 : 32'd1);
            chk("t6_wrap", 32'(wrap), (i == 5) ? 32'd1 : 32'd0);
            step();
        end
        do_stop();
        chk("t6_stop_busy", 32'(busy), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
